config_bus_arbiter: RTL and testbench

- Shares one tile's configuration bus between NUM_REQ independent requesters, e.g. the global config controller and a debug/JTAG port.
- Accepts one request at a time using round-robin priority.
- Drives a single read or write strobe onto the core's config_config_addr/config_config_data/config_read/config_write inputs.
- Returns an ack (write) or captured read_config_data (read) to the granted requester.
- Sits between the fabric config network and a core such as DummyCore.

---
 rtl/config_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_config_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_bus_arbiter.sv
// -----------------------------------------------------------------------------
// config_bus_arbiter
//
// Shares one tile's configuration bus between NUM_REQ requesters (for example
// the global config controller and a debug port). One request is accepted at
// a time with round-robin priority, turned into a single read or write strobe
// towards the core, and completed with a one-cycle response pulse back to the
// granted requester.
//
// Ports:
//   clk                 clock
//   reset               synchronous, active-high reset
//   req_valid[N]        per-requester request valid
//   req_ready[N]        per-requester accept (one-hot or zero, IDLE only)
//   req_write[N]        1 = write, 0 = read
//   req_addr[N*AW]      packed addresses, requester i at [i*AW +: AW]
//   req_data[N*DW]      packed write data, requester i at [i*DW +: DW]
//   resp_valid[N]       completion pulse to the granted requester
//   resp_data[DW]       read data (0 for write acks)
//   config_config_addr  address to core
//   config_config_data  write data to core
//   config_read         read strobe to core
//   config_write        write strobe to core
//   read_config_data    read data from core
// -----------------------------------------------------------------------------
module config_bus_arbiter #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               resp_valid,
   output logic [DATA_WIDTH-1:0]            resp_data,
   output logic [ADDR_WIDTH-1:0]            config_config_addr,
   output logic [DATA_WIDTH-1:0]            config_config_data,
   output logic                             config_read,
   output logic                             config_write,
   input  logic [DATA_WIDTH-1:0]            read_config_data
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [IDX_W-1:0]        r_grant;
   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [CNT_W-1:0]        r_cnt;

   logic                    w_found;
   logic [NUM_REQ-1:0]      w_pick;
   logic [IDX_W-1:0]        w_grant_idx;
   logic                    w_grant_write;
   logic [ADDR_WIDTH-1:0]   w_grant_addr;
   logic [DATA_WIDTH-1:0]   w_grant_data;
   logic                    w_handshake;
   logic [IDX_W-1:0]        w_rr_next;

   // Round-robin search: first valid requester at or above r_rr_ptr, wrapping
   // at NUM_REQ (which need not be a power of two).
   always_comb begin : p_arb
      int unsigned j;
      w_found       = 1'b0;
      w_pick        = '0;
      w_grant_idx   = '0;
      w_grant_write = 1'b0;
      w_grant_addr  = '0;
      w_grant_data  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = 32'(r_rr_ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!w_found && req_valid[j]) begin
            w_found       = 1'b1;
            w_pick[j]     = 1'b1;
            w_grant_idx   = IDX_W'(j);
            w_grant_write = req_write[j];
            w_grant_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            w_grant_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_handshake = (r_state == StIdle) && w_found;
   assign req_ready   = (r_state == StIdle) ? w_pick : '0;
   assign w_rr_next   = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_handshake) w_state_next = StIssue;
         StIssue: w_state_next = r_write ? StResp : StWait;
         StWait:  if (r_cnt == '0) w_state_next = StResp;
         StResp:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_rdata  <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_handshake) begin
            r_grant  <= w_grant_idx;
            r_write  <= w_grant_write;
            r_addr   <= w_grant_addr;
            r_data   <= w_grant_data;
            r_rdata  <= '0;
            r_rr_ptr <= w_rr_next;
         end
         // Counter is loaded while leaving ISSUE so WAIT lasts READ_LATENCY cycles.
         if (r_state == StIssue) begin
            r_cnt <= CNT_W'(READ_LATENCY - 1);
         end else if (r_state == StWait && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (r_state == StWait && r_cnt == '0) begin
            r_rdata <= read_config_data;
         end
      end
   end

   // Bus and response outputs decode the registered state only.
   always_comb begin
      config_config_addr = '0;
      config_config_data = '0;
      config_read        = 1'b0;
      config_write       = 1'b0;
      resp_valid         = '0;
      resp_data          = '0;
      unique case (r_state)
         StIssue: begin
            config_config_addr = r_addr;
            config_write       = r_write;
            config_read        = !r_write;
            config_config_data = r_write ? r_data : '0;
         end
         StWait: begin
            config_config_addr = r_addr;
         end
         StResp: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               resp_valid[i] = (r_grant == IDX_W'(i));
            end
            resp_data = r_write ? '0 : r_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_config_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_config_bus_arbiter
//
// Directed bench for config_bus_arbiter. Instance A: NUM_REQ=2, READ_LATENCY=1.
// Instance B: NUM_REQ=3, READ_LATENCY=3. Each has a small core model whose
// read data is only valid exactly READ_LATENCY cycles after the read strobe.
// -----------------------------------------------------------------------------
module tb_config_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int viol     = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A ----------------
   logic        a_rst;
   logic [1:0]  a_valid, a_ready, a_write, a_resp_valid;
   logic [15:0] a_addr;
   logic [63:0] a_data;
   logic [31:0] a_resp_data, a_cfg_data, a_rdata;
   logic [7:0]  a_cfg_addr;
   logic        a_cfg_read, a_cfg_write;

   config_bus_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_a (
      .clk(clk), .reset(a_rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
      .req_addr(a_addr), .req_data(a_data), .resp_valid(a_resp_valid), .resp_data(a_resp_data),
      .config_config_addr(a_cfg_addr), .config_config_data(a_cfg_data),
      .config_read(a_cfg_read), .config_write(a_cfg_write), .read_config_data(a_rdata)
   );

   logic [31:0] a_mem [256];
   logic        a_pv;
   logic [31:0] a_pd;
   always @(posedge clk) begin
      if (a_cfg_write) a_mem[a_cfg_addr] <= a_cfg_data;
      a_pv <= a_cfg_read;
      a_pd <= a_mem[a_cfg_addr];
   end
   assign a_rdata = a_pv ? a_pd : 32'hBADBAD00;

   // ---------------- instance B ----------------
   logic        b_rst;
   logic [2:0]  b_valid, b_ready, b_write, b_resp_valid;
   logic [23:0] b_addr;
   logic [95:0] b_data;
   logic [31:0] b_resp_data, b_cfg_data, b_rdata;
   logic [7:0]  b_cfg_addr;
   logic        b_cfg_read, b_cfg_write;

   config_bus_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut_b (
      .clk(clk), .reset(b_rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
      .req_addr(b_addr), .req_data(b_data), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
      .config_config_addr(b_cfg_addr), .config_config_data(b_cfg_data),
      .config_read(b_cfg_read), .config_write(b_cfg_write), .read_config_data(b_rdata)
   );

   logic [31:0] b_mem [256];
   logic [2:0]  b_pv;
   logic [31:0] b_pd [3];
   always @(posedge clk) begin
      if (b_cfg_write) b_mem[b_cfg_addr] <= b_cfg_data;
      b_pv  <= {b_pv[1:0], b_cfg_read};
      b_pd[0] <= b_mem[b_cfg_addr];
      b_pd[1] <= b_pd[0];
      b_pd[2] <= b_pd[1];
   end
   assign b_rdata = b_pv[2] ? b_pd[2] : 32'hBADBAD00;

   // Strobe exclusivity and one-hot-or-zero ready, watched throughout.
   always @(negedge clk) begin
      if (a_cfg_read && a_cfg_write) viol++;
      if (b_cfg_read && b_cfg_write) viol++;
      if ($countones(a_ready) > 1) viol++;
      if ($countones(b_ready) > 1) viol++;
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant_a(output logic [1:0] g, output int n);
      bit done = 1'b0;
      g = '0;
      n = -1;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk);
         if (a_ready != 2'b00) begin
            g = a_ready;
            n = i;
            done = 1'b1;
         end
      end
   endtask

   task automatic wait_grant_b(output logic [2:0] g, output int n);
      bit done = 1'b0;
      g = '0;
      n = -1;
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         if (b_ready != 3'b000) begin
            g = b_ready;
            n = i;
            done = 1'b1;
         end
      end
   endtask

   logic [1:0] ga;
   logic [2:0] gb;
   int         gap;
   logic [1:0] exp_a [4];
   logic [2:0] exp_b [3];

   initial begin
      a_rst = 1'b1; a_valid = '0; a_write = '0; a_addr = '0; a_data = '0;
      b_rst = 1'b1; b_valid = '0; b_write = '0; b_addr = '0; b_data = '0;
      repeat (3) @(posedge clk);
      #1;
      a_rst = 1'b0;
      b_rst = 1'b0;
      @(negedge clk);
      chk("a_reset_outs", {a_ready, a_resp_valid, a_resp_data, a_cfg_addr, a_cfg_data,
                           a_cfg_read, a_cfg_write}, '0);
      chk("b_reset_outs", {b_ready, b_resp_valid, b_resp_data, b_cfg_addr, b_cfg_data,
                           b_cfg_read, b_cfg_write}, '0);

      // ---- A: req0 write 0x01 <- DEADBEEF ----
      nxt();
      a_valid = 2'b01; a_write = 2'b01; a_addr = 16'h0001; a_data = {32'h0, 32'hDEADBEEF};
      @(negedge clk);
      chk("t1_ready", a_ready, 2'b01);
      nxt();
      a_valid = 2'b00;
      @(negedge clk);
      chk("t1_strobe", {a_cfg_write, a_cfg_read}, 2'b10);
      chk("t1_addr", a_cfg_addr, 8'h01);
      chk("t1_data", a_cfg_data, 32'hDEADBEEF);
      chk("t1_no_early_resp", a_resp_valid, 2'b00);
      nxt();
      @(negedge clk);
      chk("t1_resp", {a_resp_valid, a_resp_data}, {2'b01, 32'h0});
      chk("t1_resp_bus_idle", {a_cfg_write, a_cfg_read}, 2'b00);
      nxt();
      @(negedge clk);
      chk("t1_resp_one_cycle", a_resp_valid, 2'b00);

      // ---- A: req1 read 0x01 ----
      nxt();
      a_valid = 2'b10; a_write = 2'b00; a_addr = 16'h0100; a_data = '0;
      @(negedge clk);
      chk("t2_ready", a_ready, 2'b10);
      nxt();
      a_valid = 2'b00;
      @(negedge clk);
      chk("t2_strobe", {a_cfg_write, a_cfg_read, a_cfg_addr, a_cfg_data}, {2'b01, 8'h01, 32'h0});
      nxt();
      @(negedge clk);
      chk("t2_wait", {a_cfg_write, a_cfg_read, a_cfg_addr, a_resp_valid}, {2'b00, 8'h01, 2'b00});
      nxt();
      @(negedge clk);
      chk("t2_resp", {a_resp_valid, a_resp_data}, {2'b10, 32'hDEADBEEF});

      // ---- A: both valid, grants rotate 0,1,0,1 with 3-cycle spacing ----
      nxt();
      a_valid = 2'b11; a_write = 2'b11; a_addr = 16'h1110; a_data = {32'h2222, 32'h1111};
      exp_a[0] = 2'b01; exp_a[1] = 2'b10; exp_a[2] = 2'b01; exp_a[3] = 2'b10;
      for (int t = 0; t < 4; t++) begin
         wait_grant_a(ga, gap);
         chk($sformatf("t3_grant%0d", t), ga, exp_a[t]);
         chk($sformatf("t3_gap%0d", t), gap, (t == 0) ? 0 : 2);
      end
      nxt();
      a_valid = 2'b00;

      // ---- A: req1 arrives during req0's ISSUE -> req1 next ----
      repeat (2) @(posedge clk);
      #1;
      a_valid = 2'b01;
      @(negedge clk);
      chk("t4_ready0", a_ready, 2'b01);
      nxt();
      a_valid = 2'b11;
      @(negedge clk);
      chk("t4_issue_not_ready", a_ready, 2'b00);
      nxt();
      @(negedge clk);
      chk("t4_resp_not_ready", {a_resp_valid, a_ready}, {2'b01, 2'b00});
      nxt();
      @(negedge clk);
      chk("t4_ready1", a_ready, 2'b10);
      nxt();
      a_valid = 2'b00;
      repeat (3) nxt();
      @(negedge clk);
      chk("a_idle_outs", {a_ready, a_resp_valid, a_cfg_addr, a_cfg_data, a_cfg_read,
                          a_cfg_write}, '0);

      // ---- B: write req0 0x05 <- 12345678 ----
      nxt();
      b_valid = 3'b001; b_write = 3'b001; b_addr = 24'h000005; b_data = {64'h0, 32'h12345678};
      @(negedge clk);
      chk("b_w_ready", b_ready, 3'b001);
      nxt();
      b_valid = '0;
      @(negedge clk);
      chk("b_w_strobe", {b_cfg_write, b_cfg_read, b_cfg_addr, b_cfg_data},
          {2'b10, 8'h05, 32'h12345678});
      nxt();
      @(negedge clk);
      chk("b_w_resp", {b_resp_valid, b_resp_data}, {3'b001, 32'h0});

      // ---- B: read req1 0x05, latency 3 ----
      nxt();
      b_valid = 3'b010; b_write = 3'b000; b_addr = 24'h000500; b_data = '0;
      @(negedge clk);
      chk("b_r_ready", b_ready, 3'b010);
      nxt();
      b_valid = '0;
      @(negedge clk);
      chk("b_r_strobe", {b_cfg_write, b_cfg_read, b_cfg_addr}, {2'b01, 8'h05});
      for (int w = 0; w < 3; w++) begin
         nxt();
         @(negedge clk);
         chk($sformatf("b_r_wait%0d", w), {b_cfg_write, b_cfg_read, b_cfg_addr, b_resp_valid},
             {2'b00, 8'h05, 3'b000});
      end
      nxt();
      @(negedge clk);
      chk("b_r_resp", {b_resp_valid, b_resp_data}, {3'b010, 32'h12345678});

      // ---- B: read req1 again, reset during second WAIT cycle ----
      nxt();
      b_valid = 3'b010;
      @(negedge clk);
      chk("b_rst_ready", b_ready, 3'b010);
      nxt();
      b_valid = '0;
      @(negedge clk);
      chk("b_rst_strobe", {b_cfg_write, b_cfg_read}, 2'b01);
      nxt();
      nxt();
      b_rst = 1'b1;
      @(negedge clk);
      chk("b_rst_wait2", b_resp_valid, 3'b000);
      nxt();
      b_rst = 1'b0;
      @(negedge clk);
      chk("b_rst_outs", {b_ready, b_resp_valid, b_resp_data, b_cfg_addr, b_cfg_data,
                         b_cfg_read, b_cfg_write}, '0);
      for (int w = 0; w < 4; w++) begin
         nxt();
         @(negedge clk);
         chk($sformatf("b_rst_no_resp%0d", w), b_resp_valid, 3'b000);
      end
      // rr_ptr back at 0: with req1 and req2 valid, req1 must win.
      nxt();
      b_valid = 3'b110; b_write = 3'b110; b_addr = 24'h222100; b_data = {32'hC2, 32'hC1, 32'h0};
      @(negedge clk);
      chk("b_post_rst_grant", b_ready, 3'b010);
      nxt();
      b_valid = '0;
      @(negedge clk);
      chk("b_post_rst_strobe", {b_cfg_write, b_cfg_read, b_cfg_addr, b_cfg_data},
          {2'b10, 8'h21, 32'hC1});
      nxt();
      @(negedge clk);
      chk("b_post_rst_resp", {b_resp_valid, b_resp_data}, {3'b010, 32'h0});

      // ---- B: all three valid, nine grants 0,1,2 repeating; req1 reads ----
      nxt();
      b_rst = 1'b1;
      nxt();
      b_rst = 1'b0;
      b_valid = 3'b111; b_write = 3'b101; b_addr = 24'h330531; b_data = {32'hD2, 32'hD1, 32'hD0};
      exp_b[0] = 3'b001; exp_b[1] = 3'b010; exp_b[2] = 3'b100;
      for (int t = 0; t < 9; t++) begin
         wait_grant_b(gb, gap);
         chk($sformatf("t6_grant%0d", t), gb, exp_b[t % 3]);
         // Gap after a read (req1) is ISSUE + 3 WAIT + RESP.
         chk($sformatf("t6_gap%0d", t), gap, (t == 0) ? 0 : ((t % 3) == 2) ? 5 : 2);
      end
      nxt();
      b_valid = '0;
      repeat (4) nxt();

      chk("strobe_excl_ready_onehot", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
